retire_stage: RTL and testbench
===============================

Name: retire_stage

Overview:
- Sits directly downstream of the ROB in the N-way R10k core.
- Each cycle it inspects the N oldest ROB entries and picks the longest in-order prefix that is complete.
- It tells the ROB how many entries to clear (num_retiring), returns the retired instructions' T_old tags to the free list, and updates the architectural (retirement) map table it owns.
- It runs a halt FSM that stops retirement after a halt instruction retires.

Parameters:
- N, `N, superscalar width.
- ARCH_REG_SZ, 32, number of architectural registers.
- PHYS_REG_SZ, `PHYS_REG_SZ, number of physical registers; PHYS_REG_IDX_SZ = $clog2(PHYS_REG_SZ).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rob_outputs  in  N x ROB_PACKET  oldest-first ROB entries; fields used: complete, has_dest, dest_reg_idx, T_new, T_old, halt
- rob_outputs_valid  in  NUM_SCALAR_BITS  count of valid entries in rob_outputs
- num_retiring  out  NUM_SCALAR_BITS  entries the ROB clears at the next edge
- free_valid  out  N  per-lane strobe: free_tags[i] returns to the free list
- free_tags  out  N x PHYS_REG_IDX_SZ  T_old of the retiring lanes
- arch_map  out  ARCH_REG_SZ x PHYS_REG_IDX_SZ  registered retirement map
- halted  out  1  registered; high once a halt has retired
- retired_count  out  64  total retired instructions (only with the optional feature)

Behaviour:
- Eligibility: lane i is eligible iff i < rob_outputs_valid, rob_outputs[i].complete = 1, and every lane j < i is eligible.
- Halt truncation: if lane k is eligible and has halt = 1, lanes above k are not eligible, so the halt is the last instruction retired.
- num_retiring = number of eligible lanes. It is combinational from the inputs and the state registers, with no latency, because the ROB advances its head on the same edge.
- num_retiring never exceeds rob_outputs_valid.
- While halted = 1: num_retiring = 0, free_valid = 0, and arch_map is frozen.
- Freeing: free_valid[i] = eligible[i] & has_dest & (dest_reg_idx != 0); free_tags[i] = T_old (combinational).
- Map update, at the clock edge: for each eligible lane with has_dest and dest_reg_idx != 0, arch_map[dest_reg_idx] <= T_new.
- Same-register writes: when several lanes retiring in one cycle target the same register, the highest lane (youngest) wins.
- Writes to register 0 are always ignored, even though dispatch already guarantees has_dest = 0 for x0.
- FSM:
  - RUNNING -> HALTED at the edge where an eligible halt retires.
  - HALTED stays HALTED until reset.
  - halted is the registered state bit (1 in HALTED).
- Reset (synchronous, wins over everything): state = RUNNING; halted = 0; arch_map[i] = i (identity); retired_count = 0.
- While reset is high: num_retiring = 0 and free_valid = 0.
- rob_outputs_valid = 0 -> num_retiring = 0.
- All-complete full bundle -> num_retiring = N.
- First lane incomplete -> 0 retire, even if younger lanes are complete.
- ROB tail recovery does not interact with this block; only the head region is consumed.

Optional Feature:
- Macro: RETIRE_COUNT_EN.
- Defined: a 64-bit retired_count register is added; at each edge it does retired_count <= retired_count + num_retiring; it resets to 0 and wraps modulo 2^64.
- Undefined: the retired_count port and counter are absent, and there is no logic cost.

Decomposition:
- sys_defs.svh holds ROB_PACKET (with the complete and halt fields), `N, NUM_SCALAR_BITS, `PHYS_REG_SZ, ARCH_REG_SZ, and the RETIRE_STATE enum {RETIRE_RUNNING, RETIRE_HALTED}.
- One sub-module, retire_select: purely combinational prefix/eligibility logic producing the eligible mask and num_retiring.
- The map table and FSM stay in retire_stage.

Test Plan:
- Reset, then idle -> arch_map[5] = 5, halted = 0, num_retiring = 0 with rob_outputs_valid = 0.
- N = 3, valid = 3, complete = {1,1,1}, lane dests x1/x2/x3 with T_new 40/41/42 and T_old 1/2/3 -> num_retiring = 3, free_tags = {1,2,3}, free_valid = 3'b111; next cycle arch_map[1..3] = 40/41/42.
- complete = {0,1,1} (lane 0 incomplete) -> num_retiring = 0 and free_valid = 0. Then complete = {1,0,1} -> num_retiring = 1.
- Lanes 0 and 2 both write x7 (T_new 50 and 52), all complete -> arch_map[7] = 52; T_old of both lanes freed.
- Lane 1 is a complete halt, valid = 3 -> num_retiring = 2; halted = 1 next cycle; afterwards num_retiring stays 0 even with valid = 3 all complete; reset returns to RUNNING.
- Lane 0 has has_dest = 1, dest = x0 -> arch_map[0] stays 0 and free_valid[0] = 0. With RETIRE_COUNT_EN: 10 cycles of 3 retires -> retired_count = 30.

Source files
------------

// File: rtl/retire_stage_pkg.sv
// Shared retire-stage types: ROB packet, scalar-count width, retirement FSM states.
`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

package retire_stage_pkg;
  localparam int NUM_LANES       = `N;
  localparam int ARCH_REG_SZ     = 32;
  localparam int ARCH_REG_IDX_SZ = $clog2(ARCH_REG_SZ);
  localparam int PHYS_REG_SZ     = `PHYS_REG_SZ;
  localparam int PHYS_REG_IDX_SZ = $clog2(PHYS_REG_SZ);
  localparam int NUM_SCALAR_BITS = $clog2(NUM_LANES + 1);

  typedef struct packed {
    logic                       complete;
    logic                       halt;
    logic                       has_dest;
    logic [ARCH_REG_IDX_SZ-1:0] dest_reg_idx;
    logic [PHYS_REG_IDX_SZ-1:0] T_new;
    logic [PHYS_REG_IDX_SZ-1:0] T_old;
  } ROB_PACKET;

  typedef enum logic {
    RETIRE_RUNNING = 1'b0,
    RETIRE_HALTED  = 1'b1
  } RETIRE_STATE;
endpackage

// File: rtl/retire_stage_select.sv
// In-order complete-prefix finder over the oldest ROB lanes; a retiring halt closes the prefix.
module retire_select
  import retire_stage_pkg::*;
(
  input  logic                             reset,
  input  logic                             halted,
  input  ROB_PACKET [NUM_LANES-1:0]        rob_outputs,
  input  logic      [NUM_SCALAR_BITS-1:0]  rob_outputs_valid,
  output logic      [NUM_LANES-1:0]        eligible,
  output logic      [NUM_SCALAR_BITS-1:0]  num_retiring
);
  logic chain_ok;

  always_comb begin
    eligible     = '0;
    num_retiring = '0;
    chain_ok     = !reset && !halted;
    for (int i = 0; i < NUM_LANES; i++) begin
      eligible[i]  = chain_ok && (NUM_SCALAR_BITS'(i) < rob_outputs_valid) &&
                     rob_outputs[i].complete;
      // a halt is the last instruction to leave in its bundle
      chain_ok     = eligible[i] && !rob_outputs[i].halt;
      num_retiring = num_retiring + NUM_SCALAR_BITS'(eligible[i]);
    end
  end
endmodule

// File: rtl/retire_stage.sv
// Retire stage: frees T_old tags, owns the retirement map, halts after a halt retires.
// Optional RETIRE_COUNT_EN adds a 64-bit retired-instruction counter.
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic                                          clock,
  input  logic                                          reset,
  input  ROB_PACKET [NUM_LANES-1:0]                     rob_outputs,
  input  logic      [NUM_SCALAR_BITS-1:0]               rob_outputs_valid,
  output logic      [NUM_SCALAR_BITS-1:0]               num_retiring,
  output logic      [NUM_LANES-1:0]                     free_valid,
  output logic      [NUM_LANES-1:0][PHYS_REG_IDX_SZ-1:0] free_tags,
  output logic      [ARCH_REG_SZ-1:0][PHYS_REG_IDX_SZ-1:0] arch_map,
`ifdef RETIRE_COUNT_EN
  output logic      [63:0]                              retired_count,
`endif
  output logic                                          halted
);
  RETIRE_STATE state_q, state_d;
  logic [ARCH_REG_SZ-1:0][PHYS_REG_IDX_SZ-1:0] arch_map_q, arch_map_d;
  logic [NUM_LANES-1:0] eligible;

  retire_select u_select (
    .reset             (reset),
    .halted            (state_q == RETIRE_HALTED),
    .rob_outputs       (rob_outputs),
    .rob_outputs_valid (rob_outputs_valid),
    .eligible          (eligible),
    .num_retiring      (num_retiring)
  );

  always_comb begin
    free_valid = '0;
    free_tags  = '0;
    arch_map_d = arch_map_q;
    state_d    = state_q;
    // ascending lane order lets the youngest same-register write win
    for (int i = 0; i < NUM_LANES; i++) begin
      free_tags[i]  = rob_outputs[i].T_old;
      free_valid[i] = eligible[i] && rob_outputs[i].has_dest &&
                      (rob_outputs[i].dest_reg_idx != '0);
      if (free_valid[i])
        arch_map_d[rob_outputs[i].dest_reg_idx] = rob_outputs[i].T_new;
      if (eligible[i] && rob_outputs[i].halt)
        state_d = RETIRE_HALTED;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RETIRE_RUNNING;
      for (int i = 0; i < ARCH_REG_SZ; i++)
        arch_map_q[i] <= PHYS_REG_IDX_SZ'(i);
    end else begin
      state_q    <= state_d;
      arch_map_q <= arch_map_d;
    end
  end

  assign arch_map = arch_map_q;
  assign halted   = (state_q == RETIRE_HALTED);

`ifdef RETIRE_COUNT_EN
  logic [63:0] retired_count_q, retired_count_d;

  always_comb retired_count_d = retired_count_q + 64'(num_retiring);

  always_ff @(posedge clock) begin
    if (reset) retired_count_q <= '0;
    else       retired_count_q <= retired_count_d;
  end

  assign retired_count = retired_count_q;
`endif
endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage with N = 3 lanes.
module tb_retire_stage;
  import retire_stage_pkg::*;

  logic clock = 1'b0;
  logic reset;
  ROB_PACKET [NUM_LANES-1:0]                     rob_outputs;
  logic      [NUM_SCALAR_BITS-1:0]               rob_outputs_valid;
  logic      [NUM_SCALAR_BITS-1:0]               num_retiring;
  logic      [NUM_LANES-1:0]                     free_valid;
  logic      [NUM_LANES-1:0][PHYS_REG_IDX_SZ-1:0] free_tags;
  logic      [ARCH_REG_SZ-1:0][PHYS_REG_IDX_SZ-1:0] arch_map;
  logic                                          halted;
`ifdef RETIRE_COUNT_EN
  logic      [63:0]                              retired_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  retire_stage dut (
    .clock             (clock),
    .reset             (reset),
    .rob_outputs       (rob_outputs),
    .rob_outputs_valid (rob_outputs_valid),
    .num_retiring      (num_retiring),
    .free_valid        (free_valid),
    .free_tags         (free_tags),
    .arch_map          (arch_map),
`ifdef RETIRE_COUNT_EN
    .retired_count     (retired_count),
`endif
    .halted            (halted)
  );

  function automatic ROB_PACKET mk(input logic c, input logic h, input logic hd,
                                   input int dst, input int tn, input int to);
    ROB_PACKET p;
    p.complete     = c;
    p.halt         = h;
    p.has_dest     = hd;
    p.dest_reg_idx = ARCH_REG_IDX_SZ'(dst);
    p.T_new        = PHYS_REG_IDX_SZ'(tn);
    p.T_old        = PHYS_REG_IDX_SZ'(to);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle away from it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rob_outputs_valid = '0;
    for (int i = 0; i < NUM_LANES; i++) rob_outputs[i] = mk(1, 0, 1, i + 1, 20, 21);
    tick();
    rob_outputs_valid = 2'd3;
    #1;
    chk("reset_nr", 64'(num_retiring), 64'd0);
    chk("reset_fv", 64'(free_valid), 64'd0);
    tick();
    reset = 1'b0;
    rob_outputs_valid = '0;
    #1;
    chk("idle_map5", 64'(arch_map[5]), 64'd5);
    chk("idle_halted", 64'(halted), 64'd0);
    chk("idle_nr", 64'(num_retiring), 64'd0);

    // full bundle, dests x1/x2/x3
    rob_outputs[0] = mk(1, 0, 1, 1, 40, 1);
    rob_outputs[1] = mk(1, 0, 1, 2, 41, 2);
    rob_outputs[2] = mk(1, 0, 1, 3, 42, 3);
    rob_outputs_valid = 2'd3;
    #1;
    chk("full_nr", 64'(num_retiring), 64'd3);
    chk("full_fv", 64'(free_valid), 64'b111);
    chk("full_ft0", 64'(free_tags[0]), 64'd1);
    chk("full_ft1", 64'(free_tags[1]), 64'd2);
    chk("full_ft2", 64'(free_tags[2]), 64'd3);
    tick();
    rob_outputs_valid = '0;
    #1;
    chk("full_map1", 64'(arch_map[1]), 64'd40);
    chk("full_map2", 64'(arch_map[2]), 64'd41);
    chk("full_map3", 64'(arch_map[3]), 64'd42);

    // oldest incomplete blocks everything
    rob_outputs[0].complete = 1'b0;
    rob_outputs_valid = 2'd3;
    #1;
    chk("head_incomplete_nr", 64'(num_retiring), 64'd0);
    chk("head_incomplete_fv", 64'(free_valid), 64'd0);
    rob_outputs[0].complete = 1'b1;
    rob_outputs[1].complete = 1'b0;
    #1;
    chk("gap_nr", 64'(num_retiring), 64'd1);
    chk("gap_fv", 64'(free_valid), 64'b001);
    rob_outputs[1].complete = 1'b1;
    rob_outputs_valid = 2'd2;
    #1;
    chk("valid2_nr", 64'(num_retiring), 64'd2);
    rob_outputs_valid = '0;

    // same-register writes: youngest wins
    rob_outputs[0] = mk(1, 0, 1, 7, 50, 10);
    rob_outputs[1] = mk(1, 0, 1, 8, 51, 11);
    rob_outputs[2] = mk(1, 0, 1, 7, 52, 12);
    rob_outputs_valid = 2'd3;
    #1;
    chk("waw_fv", 64'(free_valid), 64'b111);
    chk("waw_ft0", 64'(free_tags[0]), 64'd10);
    chk("waw_ft2", 64'(free_tags[2]), 64'd12);
    tick();
    rob_outputs_valid = '0;
    #1;
    chk("waw_map7", 64'(arch_map[7]), 64'd52);
    chk("waw_map8", 64'(arch_map[8]), 64'd51);

    // write to x0 is ignored
    rob_outputs[0] = mk(1, 0, 1, 0, 60, 20);
    rob_outputs_valid = 2'd1;
    #1;
    chk("x0_nr", 64'(num_retiring), 64'd1);
    chk("x0_fv", 64'(free_valid), 64'd0);
    tick();
    rob_outputs_valid = '0;
    #1;
    chk("x0_map0", 64'(arch_map[0]), 64'd0);

    // halt in lane 1 truncates lane 2
    rob_outputs[0] = mk(1, 0, 1, 9, 30, 13);
    rob_outputs[1] = mk(1, 1, 0, 0, 0, 0);
    rob_outputs[2] = mk(1, 0, 1, 10, 31, 14);
    rob_outputs_valid = 2'd3;
    #1;
    chk("halt_nr", 64'(num_retiring), 64'd2);
    chk("halt_fv", 64'(free_valid), 64'b001);
    chk("halt_pre", 64'(halted), 64'd0);
    tick();
    chk("halt_set", 64'(halted), 64'd1);
    rob_outputs[1].halt = 1'b0;
    #1;
    chk("halted_nr", 64'(num_retiring), 64'd0);
    chk("halted_fv", 64'(free_valid), 64'd0);
    tick();
    chk("halted_map9", 64'(arch_map[9]), 64'd30);
    chk("halted_map10", 64'(arch_map[10]), 64'd10);
    chk("halted_sticky", 64'(halted), 64'd1);

    // reset recovers RUNNING and the identity map
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) rob_outputs[i] = mk(1, 0, 0, 0, 0, 0);
    #1;
    chk("rst2_halted", 64'(halted), 64'd0);
    chk("rst2_map7", 64'(arch_map[7]), 64'd7);
    chk("rst2_map9", 64'(arch_map[9]), 64'd9);
    chk("rst2_nr", 64'(num_retiring), 64'd3);
`ifdef RETIRE_COUNT_EN
    chk("cnt_reset", retired_count, 64'd0);
`endif
    for (int c = 0; c < 10; c++) tick();
    rob_outputs_valid = '0;
    #1;
`ifdef RETIRE_COUNT_EN
    chk("cnt_30", retired_count, 64'd30);
`endif
    chk("cnt_map1", 64'(arch_map[1]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
